// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - state_t   : control FSM state encoding
//   - OP_*      : instruction[31:26] opcodes recognised by the controller
//   - FUNCT_*   : instruction[5:0] function codes for R-type instructions
//   - ALU_*     : alu_op encodings driven to the datapath ALU
// ----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTE,
        ALUWB,
        BRANCH,
        ADDIEXE,
        ADDIWB,
        JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

endpackage

// File: rtl/alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Combinational decode of an R-type funct field into an ALU opcode.
// Ports:
//   funct   in  6  instruction[5:0]
//   alu_op  out 3  ALU opcode (ALU_ADD when funct is not recognised)
//   illegal out 1  funct is not one of add/sub/and/or/slt
// ----------------------------------------------------------------------------
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       illegal
);

    // Unknown functs fall back to add so the ALU still sees a defined opcode
    // while the controller flags the instruction as illegal.
    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (funct)
            FUNCT_ADD: alu_op = ALU_ADD;
            FUNCT_SUB: alu_op = ALU_SUB;
            FUNCT_AND: alu_op = ALU_AND;
            FUNCT_OR:  alu_op = ALU_OR;
            FUNCT_SLT: alu_op = ALU_SLT;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// ----------------------------------------------------------------------------
// mips_mc_control
// Moore-style control FSM for a multicycle MIPS datapath supporting
// lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.
// Optional feature: define MIPS_CTRL_BNE_EN to also support bne
// (op 000101), which branches when the ALU zero flag is clear.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   op, funct            opcode and function fields of the current IR
//   zero                 ALU zero flag
//   mem_ready            memory completes the current access this cycle
//   alu_op               ALU opcode
//   alusrca, alusrcb     ALU operand selects
//   pcsrc                PC source select
//   iord, memtoreg,
//   regdst               address / write-back / destination selects
//   mem_req, memwrite,
//   irwrite, regwrite,
//   pcen                 memory request, store, IR load, RF write, PC load
//   illegal_op           one-cycle pulse on an undecodable instruction
// ----------------------------------------------------------------------------
module mips_mc_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       mem_req,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       pcen,
    output logic       illegal_op
);

    state_t     state;
    state_t     next_state;
    logic [2:0] funct_alu_op;
    logic       funct_illegal;

    alu_decoder u_alu_decoder (
        .funct   (funct),
        .alu_op  (funct_alu_op),
        .illegal (funct_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        alu_op     = ALU_AND;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        pcen       = 1'b0;
        illegal_op = 1'b0;

        case (state)
            // PC + 4 is computed every fetch cycle, but IR and PC only
            // load on the cycle memory actually returns the instruction.
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                alu_op  = ALU_ADD;
                if (mem_ready) begin
                    irwrite    = 1'b1;
                    pcen       = 1'b1;
                    next_state = DECODE;
                end
            end

            // The ALU speculatively forms the branch target here so that
            // BRANCH can load it from ALUOut.
            DECODE: begin
                alusrcb = 2'b11;
                alu_op  = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       next_state = BRANCH;
`endif
                    OP_ADDI:      next_state = ADDIEXE;
                    OP_J:         next_state = JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end

            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alu_op     = ALU_ADD;
                next_state = (op == OP_SW) ? MEMWR : MEMRD;
            end

            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    next_state = MEMWB;
                end
            end

            MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                next_state = FETCH;
            end

            // memwrite stays high for the whole access, including waits.
            MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    next_state = FETCH;
                end
            end

            // A bad funct is caught here and the write-back is skipped.
            EXECUTE: begin
                alusrca = 1'b1;
                alu_op  = funct_alu_op;
                if (funct_illegal) begin
                    illegal_op = 1'b1;
                    next_state = FETCH;
                end else begin
                    next_state = ALUWB;
                end
            end

            ALUWB: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                next_state = FETCH;
            end

            BRANCH: begin
                alusrca    = 1'b1;
                alu_op     = ALU_SUB;
                pcsrc      = 2'b01;
`ifdef MIPS_CTRL_BNE_EN
                pcen       = (op == OP_BNE) ? ~zero : zero;
`else
                pcen       = zero;
`endif
                next_state = FETCH;
            end

            ADDIEXE: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alu_op     = ALU_ADD;
                next_state = ADDIWB;
            end

            ADDIWB: begin
                regwrite   = 1'b1;
                next_state = FETCH;
            end

            JUMP: begin
                pcsrc      = 2'b10;
                pcen       = 1'b1;
                next_state = FETCH;
            end

            default: next_state = FETCH;
        endcase

        // While reset is held the state register may still hold a stale
        // state, so suppress every architectural side effect it would cause.
        if (reset) begin
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            pcen       = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// ----------------------------------------------------------------------------
// tb_mips_mc_control
// Self-checking bench for mips_mc_control. Each cycle the expected control
// word is pushed onto a scoreboard when the inputs are driven and popped and
// compared once the outputs have settled, away from the rising edge.
// Honours MIPS_CTRL_BNE_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_mips_mc_control;
    import mips_pkg::*;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       mem_req;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       pcen;
        logic       illegal_op;
    } ctl_t;

    // memwrite, irwrite, regwrite, pcen, illegal_op
    localparam logic [16:0] ENABLE_MASK = 17'h0001F;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [2:0] alu_op;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       pcen;
    logic       illegal_op;

    ctl_t  act;
    ctl_t  exp_q[$];
    string tag_q[$];
    int    checks;
    int    errors;

    mips_mc_control dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .mem_req    (mem_req),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .pcen       (pcen),
        .illegal_op (illegal_op)
    );

    assign act = '{alu_op, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst,
                   mem_req, memwrite, irwrite, regwrite, pcen, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for each FSM state, written straight from the
    // state descriptions; anything not set stays 0.
    function automatic ctl_t e_fetch(input logic ready);
        ctl_t c = '0;
        c.mem_req = 1'b1; c.alusrcb = 2'b01; c.alu_op = ALU_ADD;
        c.irwrite = ready; c.pcen = ready;
        return c;
    endfunction

    function automatic ctl_t e_decode(input logic ill);
        ctl_t c = '0;
        c.alusrcb = 2'b11; c.alu_op = ALU_ADD; c.illegal_op = ill;
        return c;
    endfunction

    function automatic ctl_t e_memadr();
        ctl_t c = '0;
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alu_op = ALU_ADD;
        return c;
    endfunction

    function automatic ctl_t e_memrd();
        ctl_t c = '0;
        c.mem_req = 1'b1; c.iord = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_memwb();
        ctl_t c = '0;
        c.regwrite = 1'b1; c.memtoreg = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_memwr();
        ctl_t c = '0;
        c.mem_req = 1'b1; c.iord = 1'b1; c.memwrite = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_execute(input logic [2:0] aop, input logic ill);
        ctl_t c = '0;
        c.alusrca = 1'b1; c.alu_op = aop; c.illegal_op = ill;
        return c;
    endfunction

    function automatic ctl_t e_aluwb();
        ctl_t c = '0;
        c.regwrite = 1'b1; c.regdst = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_branch(input logic take);
        ctl_t c = '0;
        c.alusrca = 1'b1; c.alu_op = ALU_SUB; c.pcsrc = 2'b01; c.pcen = take;
        return c;
    endfunction

    function automatic ctl_t e_addiwb();
        ctl_t c = '0;
        c.regwrite = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_jump();
        ctl_t c = '0;
        c.pcsrc = 2'b10; c.pcen = 1'b1;
        return c;
    endfunction

    task automatic check_output(input string tag, input logic [16:0] actual,
                                input logic [16:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %05h expected %05h", tag, actual, expected);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, record the
    // expected word, then pop it and compare once the outputs have settled.
    task automatic apply_stimulus(input string tag, input logic rst,
                                  input logic [5:0] op_i, input logic [5:0] funct_i,
                                  input logic zero_i, input logic ready_i,
                                  input ctl_t exp_i);
        ctl_t  e;
        string t;
        @(negedge clk);
        reset     = rst;
        op        = op_i;
        funct     = funct_i;
        zero      = zero_i;
        mem_ready = ready_i;
        exp_q.push_back(exp_i);
        tag_q.push_back(tag);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_output(t, act, e);
    endtask

    task automatic run_rtype(input string name, input logic [5:0] f,
                             input logic [2:0] aop);
        apply_stimulus({name, ".fetch"}, 1'b0, OP_RTYPE, f, 1'b0, 1'b1, e_fetch(1'b1));
        apply_stimulus({name, ".decode"}, 1'b0, OP_RTYPE, f, 1'b0, 1'b1, e_decode(1'b0));
        apply_stimulus({name, ".exec"}, 1'b0, OP_RTYPE, f, 1'b0, 1'b1, e_execute(aop, 1'b0));
        apply_stimulus({name, ".aluwb"}, 1'b0, OP_RTYPE, f, 1'b0, 1'b1, e_aluwb());
    endtask

    task automatic run_branch(input string name, input logic [5:0] o,
                              input logic z, input logic take);
        apply_stimulus({name, ".fetch"}, 1'b0, o, 6'd0, z, 1'b1, e_fetch(1'b1));
        apply_stimulus({name, ".decode"}, 1'b0, o, 6'd0, z, 1'b1, e_decode(1'b0));
        apply_stimulus({name, ".branch"}, 1'b0, o, 6'd0, z, 1'b1, e_branch(take));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        op        = OP_LW;
        funct     = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Reset held: no enables may leak out whatever the state register holds.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_output("reset.enables", act & ENABLE_MASK, 17'h0);
        end

        // lw with no wait; mem_ready low where it must be ignored.
        apply_stimulus("lw.fetch", 1'b0, OP_LW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        apply_stimulus("lw.decode", 1'b0, OP_LW, 6'd0, 1'b0, 1'b0, e_decode(1'b0));
        apply_stimulus("lw.memadr", 1'b0, OP_LW, 6'd0, 1'b0, 1'b0, e_memadr());
        apply_stimulus("lw.memrd", 1'b0, OP_LW, 6'd0, 1'b0, 1'b1, e_memrd());
        apply_stimulus("lw.memwb", 1'b0, OP_LW, 6'd0, 1'b0, 1'b0, e_memwb());

        // sw with three wait cycles: memwrite held for four cycles.
        apply_stimulus("sw.fetch", 1'b0, OP_SW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        apply_stimulus("sw.decode", 1'b0, OP_SW, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
        apply_stimulus("sw.memadr", 1'b0, OP_SW, 6'd0, 1'b0, 1'b1, e_memadr());
        for (int i = 0; i < 3; i++)
            apply_stimulus("sw.memwr_wait", 1'b0, OP_SW, 6'd0, 1'b0, 1'b0, e_memwr());
        apply_stimulus("sw.memwr_done", 1'b0, OP_SW, 6'd0, 1'b0, 1'b1, e_memwr());

        // R-type: sub follows sw, so exactly one FETCH precedes its DECODE.
        run_rtype("sub", FUNCT_SUB, ALU_SUB);
        run_rtype("slt", FUNCT_SLT, ALU_SLT);
        run_rtype("and", FUNCT_AND, ALU_AND);
        run_rtype("or", FUNCT_OR, ALU_OR);
        run_rtype("add", FUNCT_ADD, ALU_ADD);

        run_branch("beq_z1", OP_BEQ, 1'b1, 1'b1);
        run_branch("beq_z0", OP_BEQ, 1'b0, 1'b0);

        // addi
        apply_stimulus("addi.fetch", 1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        apply_stimulus("addi.decode", 1'b0, OP_ADDI, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
        apply_stimulus("addi.exe", 1'b0, OP_ADDI, 6'd0, 1'b0, 1'b0, e_memadr());
        apply_stimulus("addi.wb", 1'b0, OP_ADDI, 6'd0, 1'b0, 1'b0, e_addiwb());

        // j behind a two-cycle fetch wait.
        apply_stimulus("j.fetch_wait", 1'b0, OP_J, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));
        apply_stimulus("j.fetch_wait", 1'b0, OP_J, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));
        apply_stimulus("j.fetch", 1'b0, OP_J, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        apply_stimulus("j.decode", 1'b0, OP_J, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
        apply_stimulus("j.jump", 1'b0, OP_J, 6'd0, 1'b0, 1'b1, e_jump());

        // Illegal opcode: pulse in DECODE, straight back to FETCH.
        apply_stimulus("ill_op.fetch", 1'b0, 6'b111111, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        apply_stimulus("ill_op.decode", 1'b0, 6'b111111, 6'd0, 1'b0, 1'b1, e_decode(1'b1));

        // Illegal funct: pulse in EXECUTE with add, ALUWB skipped.
        apply_stimulus("ill_fn.fetch", 1'b0, OP_RTYPE, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        apply_stimulus("ill_fn.decode", 1'b0, OP_RTYPE, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
        apply_stimulus("ill_fn.exec", 1'b0, OP_RTYPE, 6'd0, 1'b0, 1'b1, e_execute(ALU_ADD, 1'b1));
        apply_stimulus("ill_fn.refetch", 1'b0, OP_RTYPE, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));
        apply_stimulus("ill_fn.refetch", 1'b0, OP_RTYPE, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        apply_stimulus("ill_fn.decode2", 1'b0, OP_RTYPE, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
        apply_stimulus("ill_fn.exec2", 1'b0, OP_RTYPE, 6'd0, 1'b0, 1'b1, e_execute(ALU_ADD, 1'b1));

`ifdef MIPS_CTRL_BNE_EN
        run_branch("bne_z0", OP_BNE, 1'b0, 1'b1);
        run_branch("bne_z1", OP_BNE, 1'b1, 1'b0);
`else
        apply_stimulus("bne.fetch", 1'b0, OP_BNE, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        apply_stimulus("bne.decode", 1'b0, OP_BNE, 6'd0, 1'b0, 1'b1, e_decode(1'b1));
`endif

        // Reset while a load is waiting in MEMRD: access abandoned, no write-back.
        apply_stimulus("rst_rd.fetch", 1'b0, OP_LW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        apply_stimulus("rst_rd.decode", 1'b0, OP_LW, 6'd0, 1'b0, 1'b1, e_decode(1'b0));
        apply_stimulus("rst_rd.memadr", 1'b0, OP_LW, 6'd0, 1'b0, 1'b1, e_memadr());
        apply_stimulus("rst_rd.memrd", 1'b0, OP_LW, 6'd0, 1'b0, 1'b0, e_memrd());
        apply_stimulus("rst_rd.reset", 1'b1, OP_LW, 6'd0, 1'b0, 1'b1, e_memrd());
        apply_stimulus("rst_rd.fetch_after", 1'b0, OP_LW, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));
        apply_stimulus("rst_rd.fetch2", 1'b0, OP_LW, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
        apply_stimulus("rst_rd.decode2", 1'b0, OP_LW, 6'd0, 1'b0, 1'b1, e_decode(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  6  instruction[31:26], valid while IR holds current instruction.
REQ-005 funct  in  6  instruction[5:0].
REQ-006 zero  in  1  ALU zero flag from the datapath ALU.
REQ-007 mem_ready  in  1  memory completes the current access this cycle.
REQ-008 alu_op  out  3  ALU opcode: 0 and, 1 or, 2 add, 6 sub, 7 slt.
REQ-009 alusrca  out  1  ALU A source: 0 PC, 1 register A.
REQ-010 alusrcb  out  2  ALU B source: 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-011 pcsrc  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 iord, memtoreg, regdst  out  1 each  address, write-back and destination selects.
REQ-013 mem_req, memwrite, irwrite, regwrite, pcen  out  1 each  memory request, store, IR load, RF write, PC load.
REQ-014 illegal_op  out  1  one-cycle pulse on an undecodable instruction.

Function
REQ-015 Moore FSM, states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXE, ADDIWB, JUMP.
REQ-016 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alu_op=2, pcsrc=00; irwrite and pcen assert only in the cycle mem_ready=1; FETCH holds until mem_ready=1, then goes to DECODE.
REQ-017 DECODE: alusrca=0, alusrcb=11, alu_op=2 (branch target into ALUOut); next state by op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEXE, 000010 -> JUMP; other op -> FETCH with illegal_op=1.
REQ-018 MEMADR: alusrca=1, alusrcb=10, alu_op=2; lw -> MEMRD, sw -> MEMWR.
REQ-019 MEMRD: mem_req=1, iord=1; holds until mem_ready=1, then goes to MEMWB.
REQ-020 MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
REQ-021 MEMWR: mem_req=1, iord=1, memwrite=1; holds until mem_ready=1, then goes to FETCH.
REQ-022 EXECUTE: alusrca=1, alusrcb=00, alu_op from alu_decoder(funct): 100000 -> 2, 100010 -> 6, 100100 -> 0, 100101 -> 1, 101010 -> 7; goes to ALUWB.
REQ-023 An unknown funct in EXECUTE drives illegal_op=1 and alu_op=2, and returns to FETCH without visiting ALUWB.
REQ-024 ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
REQ-025 BRANCH: alusrca=1, alusrcb=00, alu_op=6, pcsrc=01, pcen=zero -> FETCH.
REQ-026 ADDIEXE: alusrca=1, alusrcb=10, alu_op=2 -> ADDIWB. ADDIWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
REQ-027 JUMP: pcsrc=10, pcen=1 -> FETCH.
REQ-028 Every output not listed for a state is 0 in that state; memwrite, regwrite, irwrite and pcen are never asserted outside the states named above.
REQ-029 Instruction latency in cycles, with zero memory wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; each wait cycle (mem_ready=0) adds 1.
REQ-030 mem_ready is ignored in every state without mem_req=1.

Reset
REQ-031 reset=1 at a clock edge forces FETCH from any state, including mid-wait in MEMRD/MEMWR; a pending access is abandoned.
REQ-032 During and immediately after reset, all enables (mem_req excepted), illegal_op, pcen and memwrite are 0; the FETCH outputs of REQ-016 apply from the first cycle after reset deasserts.

Configuration
REQ-033 Macro MIPS_CTRL_BNE_EN: when defined, op 000101 goes from DECODE to BRANCH with pcen=~zero; when undefined, op 000101 is illegal per REQ-017.

Structure
REQ-034 Package mips_pkg shall hold the state enum, the op/funct constants and the alu_op constants (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7).
REQ-035 Combinational sub-module alu_decoder (funct in; alu_op and illegal flag out) shall be instantiated for EXECUTE.

Verification
REQ-036 lw (op 100011), mem_ready=1 always -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 in cycle 5 only.
REQ-037 R-type sub (funct 100010) -> alu_op=6 in EXECUTE, regwrite=1 and regdst=1 in ALUWB; slt (funct 101010) -> alu_op=7.
REQ-038 beq with zero=1 -> pcen=1 and pcsrc=01 in BRANCH; with zero=0 -> pcen=0.
REQ-039 sw with mem_ready low for 3 cycles -> memwrite held 4 cycles and exactly 1 FETCH follows; fetch wait of 2 cycles -> irwrite/pcen pulse only on the ready cycle.
REQ-040 op 111111, or funct 000000 with op 000000 -> illegal_op pulses 1 cycle and regwrite stays 0; bne with MIPS_CTRL_BNE_EN, zero=0 -> pcen=1.
REQ-041 reset asserted in MEMRD -> FETCH on the next cycle, regwrite never asserted.
